// File: rtl/duty_cycle_pkg.sv
// duty_cycle_pkg
// Shared definitions for the duty-cycle controller:
//   state_t     - controller state encoding (IDLE / RUN / STOP)
//   DEF_PERIOD  - period in cycles used after reset
//   DEF_HIGH    - high-time in cycles used after reset
//   cfg_ok()    - legality check applied to every offered config
package duty_cycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam int DEF_PERIOD = 10;
    localparam int DEF_HIGH   = 5;

    // A period shorter than 2 leaves no room for a boundary distinct from
    // the first cycle; a high-time longer than the period is meaningless.
    function automatic logic cfg_ok(input int unsigned period, input int unsigned high);
        return (period >= 2) && (high <= period);
    endfunction

endpackage

// File: rtl/duty_counter.sv
// duty_counter
// Period counter plus high-time compare with registered outputs.
// The inputs describe the NEXT cycle: run says whether the next cycle is an
// active one, and period_act/high_act are the values that govern it. This
// lets wave and boundary be registered yet line up with the counter value
// they belong to, including the cycle where new settings take effect.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   run         - next cycle is RUN/STOP
//   period_act  - period governing the next cycle
//   high_act    - high-time governing the next cycle
//   wave        - registered waveform (cnt < high while active)
//   boundary    - registered, high on the last cycle of each period
module duty_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] period_act,
    input  logic [CNT_W-1:0] high_act,
    output logic             wave,
    output logic             boundary
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             run_q;

    // Entering from idle starts at 0; the registered boundary flag marks the
    // current cycle as the last of its period, so the next one wraps to 0.
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!run_q || boundary) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt      <= '0;
            wave     <= 1'b0;
            boundary <= 1'b0;
        end else begin
            run_q <= run;
            if (run) begin
                cnt      <= cnt_nxt;
                wave     <= (cnt_nxt < high_act);
                boundary <= (cnt_nxt == period_act - CNT_W'(1));
            end else begin
                cnt      <= '0;
                wave     <= 1'b0;
                boundary <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/duty_cycle_ctrl.sv
// duty_cycle_ctrl
// Programmable duty-cycle waveform controller. Configs arrive over a
// valid/ready port, wait in a shadow register and are applied only at a
// period boundary (or straight away when idle), so the waveform never
// glitches mid-period.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - run request (level)
//   cfg_valid    - config offer
//   cfg_ready    - shadow slot free
//   cfg_period   - requested period in cycles
//   cfg_high     - requested high-time in cycles
//   pwm_out      - generated waveform
//   period_done  - pulse on the last cycle of each period
//   cfg_err      - pulse the cycle after an illegal config was consumed
//   busy         - controller not idle
module duty_cycle_ctrl
    import duty_cycle_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int RST_PERIOD = DEF_PERIOD,
    parameter int RST_HIGH   = DEF_HIGH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             pwm_out,
    output logic             period_done,
    output logic             cfg_err,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] shadow_period;
    logic [CNT_W-1:0] shadow_high;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             pending;
    logic             accept;
    logic             cfg_good;
    logic             copy;
    logic             run_nxt;
    logic             boundary;
    logic             wave;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_RUN;
            ST_RUN:  if (!en) state_nxt = ST_STOP;
            ST_STOP: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (boundary) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept   = cfg_valid && !pending;
    assign cfg_good = cfg_ok(32'(cfg_period), 32'(cfg_high));
    // boundary is the registered last-cycle flag, so a config accepted on
    // that same cycle is not yet pending and waits for the next boundary.
    assign copy     = pending && ((state == ST_IDLE) || boundary);
    assign run_nxt  = (state_nxt != ST_IDLE);

    // Values that govern the next cycle, fed forward so the counter's
    // registered outputs already reflect a freshly applied config.
    assign period_nxt = copy ? shadow_period : period_act;
    assign high_nxt   = copy ? shadow_high   : high_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            period_act    <= CNT_W'(RST_PERIOD);
            high_act      <= CNT_W'(RST_HIGH);
            shadow_period <= '0;
            shadow_high   <= '0;
            pending       <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_err <= accept && !cfg_good;
            // copy needs pending=1 and accept needs pending=0: never both.
            if (copy) begin
                period_act <= shadow_period;
                high_act   <= shadow_high;
                pending    <= 1'b0;
            end else if (accept && cfg_good) begin
                shadow_period <= cfg_period;
                shadow_high   <= cfg_high;
                pending       <= 1'b1;
            end
        end
    end

    duty_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .run       (run_nxt),
        .period_act(period_nxt),
        .high_act  (high_nxt),
        .wave      (wave),
        .boundary  (boundary)
    );

    assign cfg_ready   = !pending;
    assign busy        = (state != ST_IDLE);
    assign pwm_out     = wave;
    assign period_done = boundary;

endmodule

// File: tb/tb_duty_cycle_ctrl.sv
// tb_duty_cycle_ctrl
// Table-driven bench for duty_cycle_ctrl. Each row holds the inputs driven
// before a rising edge and the outputs expected in the cycle that edge
// starts, packed as {pwm_out, period_done, cfg_ready, cfg_err, busy}.
module tb_duty_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_period = 8'd0;
    logic [7:0] cfg_high = 8'd0;
    logic       pwm_out;
    logic       period_done;
    logic       cfg_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       en;
        logic       vld;
        logic [7:0] p;
        logic [7:0] h;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    duty_cycle_ctrl #(
        .CNT_W(8),
        .RST_PERIOD(10),
        .RST_HIGH(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic e, input logic v, input logic [7:0] p,
                                input logic [7:0] h, input logic pwm, input logic done,
                                input logic rdy, input logic err, input logic bsy);
        vec_t r;
        r.en  = e;
        r.vld = v;
        r.p   = p;
        r.h   = h;
        r.exp = {pwm, done, rdy, err, bsy};
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {pwm_out, period_done, cfg_ready, cfg_err, busy};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: pwm/done/rdy/err/busy got %b, expected %b", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset defaults 10/5, en held: 5 high, 5 low, done on cnt 9.
        for (int k = 0; k < 20; k++)
            add(1, 0, 0, 0, (k % 10) < 5, (k % 10) == 9, 1, 0, 1);
        // Config 8/2 offered during cnt 2; current period finishes as 10/5.
        for (int k = 20; k < 30; k++)
            add(1, k == 23, 8'd8, 8'd2, (k % 10) < 5, (k % 10) == 9, k < 23, 0, 1);
        // New 8/2 periods; illegal configs 1/0 and 8/9 are consumed and flagged.
        for (int r = 30; r < 54; r++) begin
            int  j;
            logic v;
            j = r - 30;
            v = (r == 47) || (r == 50);
            add(1, v, (r == 47) ? 8'd1 : 8'd8, (r == 47) ? 8'd0 : 8'd9,
                (j % 8) < 2, (j % 8) == 7, 1, v, 1);
        end
        // en low sampled at cnt 3, back high at cnt 7: no gap. Then drop at
        // cnt 1 and hold: period completes, then idle.
        for (int r = 54; r < 80; r++) begin
            int  j;
            logic e;
            j = r - 30;
            e = !(((r >= 58) && (r <= 61)) || (r >= 72));
            if (r <= 77)
                add(e, 0, 0, 0, (j % 8) < 2, (j % 8) == 7, 1, 0, 1);
            else
                add(e, 0, 0, 0, 0, 0, 1, 0, 0);
        end
        // Idle: 6/0 applied the next cycle; run; 6/6 applied at next boundary.
        for (int r = 80; r < 100; r++) begin
            logic rdy;
            rdy = !((r == 80) || ((r >= 85) && (r <= 87)));
            add(r >= 82, (r == 80) || (r == 85), 8'd6, (r == 85) ? 8'd6 : 8'd0,
                r >= 88, (r >= 82) && (((r - 82) % 6) == 5), rdy, 0, r >= 82);
        end

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 5'b00100);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en         = vecs[i].en;
            cfg_valid  = vecs[i].vld;
            cfg_period = vecs[i].p;
            cfg_high   = vecs[i].h;
            tick();
            check($sformatf("row%0d", i), vecs[i].exp);
        end

        // Config 3/1 accepted on the last cycle of a 6/6 period: not applied
        // at that boundary, so the next period still runs constant high.
        en         = 1'b1;
        cfg_valid  = 1'b1;
        cfg_period = 8'd3;
        cfg_high   = 8'd1;
        tick();
        check("bnd_accept_cnt0", 5'b10001);
        cfg_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("bnd_accept_cnt%0d", k), 5'b10001);
        end

        // Asynchronous reset at cnt 4 with a config pending.
        #2 rst = 1'b1;
        #1 check("async_rst", 5'b00100);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", 5'b00100);
        rst = 1'b0;

        // Defaults back, pending config gone.
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("post_rst%0d", k), {k < 5, k == 9, 1'b1, 1'b0, 1'b1});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
